// File: rtl/fb_pkg.sv
// Shared types and default sizes for the framebuffer double-buffer controller.
package fb_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } ctrl_state_t;

    localparam int FB_ADDR_W = 15;
    localparam int FB_DATA_W = 8;
    localparam int FB_WORDS  = 32768;

endpackage

// File: rtl/fb_clear_engine.sv
// Back-buffer clear engine: walks addresses 0..CLEAR_WORDS-1 with a captured fill value,
// holding position for any cycle the write port is taken by the CPU.
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int DATA_W      = FB_DATA_W,
    parameter int CLEAR_WORDS = FB_WORDS
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              active,
    input  logic              stall,
    input  logic [DATA_W-1:0] start_value,
    output logic [ADDR_W-1:0] clear_addr,
    output logic [DATA_W-1:0] clear_value,
    output logic              clear_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLEAR_WORDS - 1);

    logic [ADDR_W-1:0] count;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count       <= '0;
            clear_value <= '0;
        end else if (start) begin
            count       <= '0;
            clear_value <= start_value;
        end else if (active && !stall) begin
            count <= clear_last ? '0 : count + 1'b1;
        end
    end

    assign clear_addr = count;
    assign clear_last = (count == LAST_ADDR);

endmodule

// File: rtl/fb_flip_ctrl.sv
// Double-buffer sequencer: tear-free flips on VBlank rise, hardware back-buffer clear
// sharing the write port with CPU writes (CPU first), and a latched VBlank NMI.
module fb_flip_ctrl
    import fb_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int DATA_W      = FB_DATA_W,
    parameter int CLEAR_WORDS = FB_WORDS
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              VBlank,
    input  logic              CpuWrite,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuData,
    input  logic              FlipReq,
    input  logic              ClearReq,
    input  logic [DATA_W-1:0] ClearValue,
    input  logic              NmiEnable,
    input  logic              NmiAck,
    output logic              WriteMem,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemData,
    output logic              BufSel,
    output logic              Busy,
    output logic              FlipPending,
    output logic              FlipDone,
    output logic              NMI_n
);

    ctrl_state_t state, next_state;

    logic              start_clear;
    logic              clear_active;
    logic [ADDR_W-1:0] clear_addr;
    logic [DATA_W-1:0] clear_value;
    logic              clear_last;
    logic              vblank_q;
    logic              vbl_rise;
    logic              flip_now;

    fb_clear_engine #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .CLEAR_WORDS(CLEAR_WORDS)
    ) u_clear (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .start      (start_clear),
        .active     (clear_active),
        .stall      (CpuWrite),
        .start_value(ClearValue),
        .clear_addr (clear_addr),
        .clear_value(clear_value),
        .clear_last (clear_last)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // The clear ends on the edge that actually issues its final write, so a CPU stall
    // on that cycle keeps us in CLEAR for one more edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ClearReq) next_state = CLEAR;
            CLEAR:   if (!CpuWrite && clear_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_clear  = 1'b0;
        clear_active = 1'b0;
        Busy         = 1'b0;
        case (state)
            IDLE:  start_clear = ClearReq;
            CLEAR: begin
                clear_active = 1'b1;
                Busy         = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            WriteMem <= 1'b0;
            MemAddr  <= '0;
            MemData  <= '0;
        end else if (CpuWrite) begin
            WriteMem <= 1'b1;
            MemAddr  <= CpuAddr;
            MemData  <= CpuData;
        end else if (clear_active) begin
            WriteMem <= 1'b1;
            MemAddr  <= clear_addr;
            MemData  <= clear_value;
        end else begin
            WriteMem <= 1'b0;
        end
    end

    assign vbl_rise = VBlank & ~vblank_q;
    assign flip_now = vbl_rise & FlipPending & ~Busy;

    // A request only becomes pending after its edge, so it can never flip on that same rise.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            vblank_q    <= 1'b0;
            BufSel      <= 1'b0;
            FlipPending <= 1'b0;
            FlipDone    <= 1'b0;
            NMI_n       <= 1'b1;
        end else begin
            vblank_q <= VBlank;
            FlipDone <= flip_now;
            if (flip_now) begin
                BufSel      <= ~BufSel;
                FlipPending <= 1'b0;
            end else if (FlipReq) begin
                FlipPending <= 1'b1;
            end
            if (vbl_rise && NmiEnable) NMI_n <= 1'b0;
            else if (NmiAck)           NMI_n <= 1'b1;
        end
    end

endmodule
